// File: rtl/bus_dispatch_ctrl.sv
// Word dispatcher for the 1-to-N_BUS CAN demux: handshake at T -> tx_valid at T+1, ack at T+k -> done at T+k+1;
// in_ready low while a word is in flight. Define DISPATCH_RETRY_EN to re-strobe once after the first timeout.
module bus_dispatch_ctrl #(
   parameter int N_BUS  = 16,
   parameter int DATA_W = 16,
   parameter int TOUT   = 255,
   parameter int TOUT_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic [4:0]        i_in_bus_id,
   output logic [4:0]        o_demux_sel,
   output logic [DATA_W-1:0] o_demux_data,
   output logic [N_BUS-1:0]  o_tx_valid,
   input  logic [N_BUS-1:0]  i_tx_ack,
   output logic              o_done,
   output logic              o_err_timeout,
   output logic              o_err_bad_id,
   output logic [4:0]        o_busy_id
);

`ifdef DISPATCH_RETRY_EN
   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_BADID, ST_GAP} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_BADID} state_t;
`endif

   localparam logic [5:0]        LP_NBUS  = 6'(N_BUS);
   localparam logic [TOUT_W-1:0] LP_TLAST = TOUT_W'(TOUT - 1);
   localparam logic [4:0]        LP_NOSEL = 5'h1F;
   localparam logic [N_BUS-1:0]  LP_ONE   = {{(N_BUS-1){1'b0}}, 1'b1};

   state_t              r_state;
   logic [TOUT_W-1:0]   r_cnt;
   logic [4:0]          r_sel;
   logic [4:0]          r_busy;
   logic [DATA_W-1:0]   r_data;
   logic [N_BUS-1:0]    r_tx_valid;
   logic                r_done;
   logic                r_err_to;
   logic                r_err_bad;
`ifdef DISPATCH_RETRY_EN
   logic                r_retried;
`endif

   logic                w_id_ok;
   logic                w_ack;
   logic [N_BUS-1:0]    w_onehot_in;
   logic [N_BUS-1:0]    w_onehot_busy;

   assign w_id_ok       = {1'b0, i_in_bus_id} < LP_NBUS;
   assign w_onehot_in   = LP_ONE << i_in_bus_id;
   assign w_onehot_busy = LP_ONE << r_busy;
   // tx_valid is one-hot on the target, so masking with it samples only the active channel's ack
   assign w_ack         = |(i_tx_ack & r_tx_valid);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_sel      <= LP_NOSEL;
         r_busy     <= LP_NOSEL;
         r_data     <= '0;
         r_tx_valid <= '0;
         r_done     <= 1'b0;
         r_err_to   <= 1'b0;
         r_err_bad  <= 1'b0;
`ifdef DISPATCH_RETRY_EN
         r_retried  <= 1'b0;
`endif
      end else begin
         r_done    <= 1'b0;
         r_err_to  <= 1'b0;
         r_err_bad <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_in_valid) begin
                  if (w_id_ok) begin
                     r_state    <= ST_SEND;
                     r_sel      <= i_in_bus_id;
                     r_busy     <= i_in_bus_id;
                     r_data     <= i_in_data;
                     r_tx_valid <= w_onehot_in;
                     r_cnt      <= '0;
`ifdef DISPATCH_RETRY_EN
                     r_retried  <= 1'b0;
`endif
                  end else begin
                     r_state   <= ST_BADID;
                     r_err_bad <= 1'b1;
                  end
               end
            end
            ST_SEND: begin
               if (w_ack) begin
                  r_done     <= 1'b1;
                  r_state    <= ST_IDLE;
                  r_tx_valid <= '0;
                  r_sel      <= LP_NOSEL;
                  r_busy     <= LP_NOSEL;
                  r_data     <= '0;
                  r_cnt      <= '0;
               end else if (r_cnt == LP_TLAST) begin
`ifdef DISPATCH_RETRY_EN
                  if (!r_retried) begin
                     r_retried  <= 1'b1;
                     r_tx_valid <= '0;
                     r_cnt      <= '0;
                     r_state    <= ST_GAP;
                  end else begin
                     r_err_to   <= 1'b1;
                     r_state    <= ST_IDLE;
                     r_tx_valid <= '0;
                     r_sel      <= LP_NOSEL;
                     r_busy     <= LP_NOSEL;
                     r_data     <= '0;
                     r_cnt      <= '0;
                  end
`else
                  r_err_to   <= 1'b1;
                  r_state    <= ST_IDLE;
                  r_tx_valid <= '0;
                  r_sel      <= LP_NOSEL;
                  r_busy     <= LP_NOSEL;
                  r_data     <= '0;
                  r_cnt      <= '0;
`endif
               end else begin
                  r_cnt <= r_cnt + TOUT_W'(1);
               end
            end
            ST_BADID: begin
               r_state <= ST_IDLE;
            end
`ifdef DISPATCH_RETRY_EN
            // one idle cycle with select/data held, then the same channel is strobed again
            ST_GAP: begin
               r_tx_valid <= w_onehot_busy;
               r_state    <= ST_SEND;
            end
`endif
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_in_ready    = (r_state == ST_IDLE);
   assign o_demux_sel   = r_sel;
   assign o_demux_data  = r_data;
   assign o_tx_valid    = r_tx_valid;
   assign o_done        = r_done;
   assign o_err_timeout = r_err_to;
   assign o_err_bad_id  = r_err_bad;
   assign o_busy_id     = r_busy;

endmodule

// File: tb/tb_bus_dispatch_ctrl.sv
// Bench for bus_dispatch_ctrl: directed and random words, expectations derived per transaction from ack timing.
module tb_bus_dispatch_ctrl;
   localparam int N_BUS  = 16;
   localparam int DATA_W = 16;
   localparam int TOUT   = 12;
`ifdef DISPATCH_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif
   localparam int LAST = RETRY ? 2*TOUT+1 : TOUT;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [4:0]        in_bus_id;
   logic [4:0]        demux_sel;
   logic [DATA_W-1:0] demux_data;
   logic [N_BUS-1:0]  tx_valid;
   logic [N_BUS-1:0]  tx_ack;
   logic              done;
   logic              err_timeout;
   logic              err_bad_id;
   logic [4:0]        busy_id;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bus_dispatch_ctrl #(.N_BUS(N_BUS), .DATA_W(DATA_W), .TOUT(TOUT), .TOUT_W(8)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_data(in_data), .i_in_bus_id(in_bus_id),
      .o_demux_sel(demux_sel), .o_demux_data(demux_data),
      .o_tx_valid(tx_valid), .i_tx_ack(tx_ack),
      .o_done(done), .o_err_timeout(err_timeout), .o_err_bad_id(err_bad_id),
      .o_busy_id(busy_id)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // cycle j counts from the first cycle after the handshake edge
   function automatic bit in_window(input int j);
      return (j >= 1 && j <= TOUT) || (RETRY && j >= TOUT+2 && j <= 2*TOUT+1);
   endfunction

   task automatic idle(input int n, input bit noise);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         tx_ack = noise ? N_BUS'($urandom) : '0;
         @(negedge clk);
         chk("idle_ready", in_ready, 1);
         chk("idle_txv", tx_valid, 0);
         chk("idle_sel", demux_sel, 5'h1F);
         chk("idle_busy", busy_id, 5'h1F);
         chk("idle_pulses", {done, err_timeout, err_bad_id}, 0);
      end
   endtask

   // a = cycle on which the target ack is pulsed (0 = never); called at a negedge with in_ready high
   task automatic send(input logic [15:0] w, input logic [4:0] id, input int a,
                       input logic [15:0] others, output int dones);
      bit          good;
      bit          acked;
      int          last_c;
      logic [15:0] oh;
      logic [31:0] sh;
      good   = (id < 5'd16);
      sh     = 32'd1 << id;
      oh     = sh[15:0];
      acked  = good && in_window(a);
      last_c = !good ? 1 : (acked ? a : LAST);
      dones  = 0;
      chk("hs_ready", in_ready, 1);
      in_valid  = 1'b1;
      in_data   = w;
      in_bus_id = id;
      tx_ack    = others & ~oh;
      for (int j = 1; j <= last_c + 1; j++) begin
         @(negedge clk);
         if (j == 1) begin
            in_valid  = 1'b0;
            in_data   = DATA_W'($urandom);
            in_bus_id = 5'($urandom);
         end
         chk("ready", in_ready, (j == last_c + 1) ? 1 : 0);
         chk("done", done, (good && acked && j == last_c + 1) ? 1 : 0);
         chk("err_timeout", err_timeout, (good && !acked && j == last_c + 1) ? 1 : 0);
         chk("err_bad_id", err_bad_id, (!good && j == 1) ? 1 : 0);
         chk("tx_valid", tx_valid, (good && j <= last_c && in_window(j)) ? oh : 16'h0);
         chk("busy_id", busy_id, (good && j <= last_c) ? id : 5'h1F);
         chk("demux_sel", demux_sel, (good && j <= last_c) ? id : 5'h1F);
         if (good && j <= last_c && in_window(j)) chk("demux_data", demux_data, w);
         if (done) dones++;
         tx_ack = (others & ~oh) | ((good && j == a) ? oh : 16'h0);
      end
   endtask

   initial begin
      int d;
      int total;
      int t0;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_bus_id = '0; tx_ack = '0;
      repeat (3) @(negedge clk);
      chk("rst_txv", tx_valid, 0);
      chk("rst_sel", demux_sel, 5'h1F);
      chk("rst_data", demux_data, 0);
      chk("rst_busy", busy_id, 5'h1F);
      rst = 1'b0;
      idle(10, 1'b0);

      send(16'hA5A5, 5'd3, 3, 16'h0, d);
      chk("t2_dones", d, 1);
      idle(2, 1'b0);
      send(16'h1234, 5'd20, 0, 16'h0, d);
      idle(2, 1'b1);
      send(16'hBEEF, 5'd7, 0, 16'h0040, d);
      chk("t4_dones", d, 0);
      send(16'h0F0F, 5'd2, TOUT, 16'hFFFF, d);
      chk("t5_dones", d, 1);
      send(16'h7777, 5'd2, LAST, 16'h0, d);
      chk("t5b_dones", d, 1);
      send(16'h5A5A, 5'd31, 0, 16'hFFFF, d);
      idle(1, 1'b0);

      // reset in the middle of a SEND to channel 15
      in_valid = 1'b1; in_data = 16'hCAFE; in_bus_id = 5'd15;
      @(negedge clk);
      in_valid = 1'b0;
      chk("t6_txv", tx_valid, 16'h8000);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_txv", tx_valid, 0);
      chk("t6_rst_sel", demux_sel, 5'h1F);
      chk("t6_rst_pulses", {done, err_timeout, err_bad_id}, 0);
      chk("t6_rst_ready", in_ready, 1);
      rst = 1'b0;
      idle(4, 1'b0);

      // back-to-back words, each acked on its first tx_valid cycle
      total = 0;
      t0 = cyc;
      for (int i = 0; i < 16; i++) begin
         send(16'(16'h1000 + i), 5'(i), 1, 16'($urandom), d);
         total += d;
      end
      chk("b2b_dones", total, 16);
      chk("b2b_cycles", cyc - t0, 32);
      idle(2, 1'b1);

      for (int k = 0; k < 40; k++) begin
         int a;
         a = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, LAST + 2));
         send(16'($urandom), 5'($urandom_range(0, 19)), a, 16'($urandom), d);
         idle(int'($urandom_range(0, 2)), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
